// File: rtl/dense_load_sequencer_pkg.sv
// Shared types and helpers for the dense-layer load sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dense_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    FIN    = 3'd4
  } state_e;

  // Weight rows equal the number of flattened input features.
  function automatic int calc_num_rows(input int w, input int h, input int d);
    return w * h * d;
  endfunction

endpackage

// File: rtl/dense_load_sequencer_if.sv
// Bundles parameter-memory, datapath and output-stream signals of the sequencer.
// Latency: none (wires only).
// Backpressure: carries out_ready_i / flattendense_ready_o between the ends.
interface dense_load_sequencer_if #(
  parameter int NUM_NEURONS = 40,
  parameter int WRES        = 8,
  parameter int BRES        = 32,
  parameter int ADDRW       = 12
);
  logic                        wmem_req_o;
  logic [ADDRW-1:0]            wmem_addr_o;
  logic [NUM_NEURONS*WRES-1:0] wmem_data_i;
  logic                        bmem_req_o;
  logic [NUM_NEURONS*BRES-1:0] bmem_data_i;
  logic                        dense_weights_valid_o;
  logic [ADDRW-1:0]            dense_weights_addr_o;
  logic [NUM_NEURONS*WRES-1:0] dense_weights_data_o;
  logic                        dense_biases_valid_o;
  logic [ADDRW-1:0]            dense_biases_addr_o;
  logic [NUM_NEURONS*BRES-1:0] dense_biases_data_o;
  logic [BRES-1:0]             dense_dwscaling_m0_o;
  logic [3:0]                  dense_dwscaling_n_o;
  logic                        feature_enable_o;
  logic                        flattendense_valid_i;
  logic                        flattendense_ready_o;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [ADDRW-1:0]            out_index_o;

  // Sequencer side.
  modport master (
    output wmem_req_o, wmem_addr_o, bmem_req_o,
    input  wmem_data_i, bmem_data_i,
    output dense_weights_valid_o, dense_weights_addr_o, dense_weights_data_o,
    output dense_biases_valid_o, dense_biases_addr_o, dense_biases_data_o,
    output dense_dwscaling_m0_o, dense_dwscaling_n_o, feature_enable_o,
    input  flattendense_valid_i, out_ready_i,
    output flattendense_ready_o, out_valid_o, out_index_o
  );

  // Memories, datapath and downstream consumer side.
  modport slave (
    input  wmem_req_o, wmem_addr_o, bmem_req_o,
    output wmem_data_i, bmem_data_i,
    input  dense_weights_valid_o, dense_weights_addr_o, dense_weights_data_o,
    input  dense_biases_valid_o, dense_biases_addr_o, dense_biases_data_o,
    input  dense_dwscaling_m0_o, dense_dwscaling_n_o, feature_enable_o,
    output flattendense_valid_i, out_ready_i,
    input  flattendense_ready_o, out_valid_o, out_index_o
  );

endinterface

// File: rtl/dense_load_sequencer_param_fetch.sv
// Weight-row / bias address generator with valids aligned to 1-cycle memory read data.
// Latency: valid/address trail the read strobe by exactly one cycle.
// Backpressure: none; one row per cycle while load_w_i is held.
module dense_param_fetch #(
  parameter int NUM_ROWS = 40,
  parameter int ADDRW    = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_w_i,
  input  logic             load_b_i,
  output logic             wmem_req_o,
  output logic [ADDRW-1:0] wmem_addr_o,
  output logic             bmem_req_o,
  output logic             w_valid_o,
  output logic [ADDRW-1:0] w_addr_o,
  output logic             b_valid_o,
  output logic             last_row_o
);

  localparam logic [ADDRW-1:0] LAST_ROW = ADDRW'(NUM_ROWS - 1);

  logic [ADDRW-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDRW-1:0] w_addr_q;
  logic             w_valid_q, b_valid_q;

  // Row counter advances while loading and parks at 0 otherwise.
  always_comb begin
    rd_cnt_d = '0;
    if (load_w_i && (rd_cnt_q != LAST_ROW)) begin
      rd_cnt_d = rd_cnt_q + ADDRW'(1);
    end
  end

  // Delay strobe and address one cycle to line up with memory read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q  <= '0;
      w_addr_q  <= '0;
      w_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      w_addr_q  <= rd_cnt_q;
      w_valid_q <= load_w_i;
      b_valid_q <= load_b_i;
    end
  end

  assign wmem_req_o  = load_w_i;
  assign wmem_addr_o = rd_cnt_q;
  assign bmem_req_o  = load_b_i;
  assign w_valid_o   = w_valid_q;
  assign w_addr_o    = w_addr_q;
  assign b_valid_o   = b_valid_q;
  assign last_row_o  = load_w_i && (rd_cnt_q == LAST_ROW);

endmodule

// File: rtl/dense_load_sequencer.sv
// Sequences one FlattenDense run: weight/bias load (skippable when resident), then output phase.
// Latency: reload run enters RUN NUM_ROWS+2 cycles after start; resident run enters RUN next cycle.
// Backpressure: out_ready_i low stalls the output count indefinitely; start_i ignored unless IDLE.
module dense_load_sequencer
  import dense_ctrl_pkg::*;
#(
  parameter int F_IN_W      = 5,
  parameter int F_IN_H      = 1,
  parameter int F_IN_D      = 8,
  parameter int NUM_NEURONS = 40,
  parameter int WRES        = 8,
  parameter int BRES        = 32,
  parameter int ADDRW       = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            reload_i,
  input  logic [BRES-1:0] m0_cfg_i,
  input  logic [3:0]      n_cfg_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            loaded_o,
  dense_load_sequencer_if.master bus
);

  localparam int NUM_ROWS = calc_num_rows(F_IN_W, F_IN_H, F_IN_D);
  localparam logic [ADDRW-1:0] LAST_OUT = ADDRW'(NUM_NEURONS - 1);

  if ((NUM_ROWS >= (1 << ADDRW)) || (NUM_NEURONS >= (1 << ADDRW))) begin : g_bad_cfg
    $error("dense_load_sequencer: NUM_ROWS/NUM_NEURONS do not fit in ADDRW bits");
  end

  state_e           state_q, state_d;
  logic [ADDRW-1:0] out_idx_q, out_idx_d;
  logic             loaded_q, loaded_d;
  logic [BRES-1:0]  m0_q, m0_d;
  logic [3:0]       n_q, n_d;
  logic             last_row;
  logic             handshake;
  logic             in_run;
  logic [NUM_NEURONS*WRES-1:0] w_row;
  logic [NUM_NEURONS*BRES-1:0] b_word;

  dense_param_fetch #(
    .NUM_ROWS (NUM_ROWS),
    .ADDRW    (ADDRW)
  ) u_fetch (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_w_i    (state_q == LOAD_W),
    .load_b_i    (state_q == LOAD_B),
    .wmem_req_o  (bus.wmem_req_o),
    .wmem_addr_o (bus.wmem_addr_o),
    .bmem_req_o  (bus.bmem_req_o),
    .w_valid_o   (bus.dense_weights_valid_o),
    .w_addr_o    (bus.dense_weights_addr_o),
    .b_valid_o   (bus.dense_biases_valid_o),
    .last_row_o  (last_row)
  );

  assign in_run    = (state_q == RUN);
  assign handshake = bus.flattendense_valid_i && bus.out_ready_i && in_run;

  // Next-state and register updates for the run sequence.
  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    loaded_d  = loaded_q;
    m0_d      = m0_q;
    n_d       = n_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          m0_d = m0_cfg_i;
          n_d  = n_cfg_i;
          if (reload_i || !loaded_q) begin
            state_d  = LOAD_W;
            loaded_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      LOAD_W: begin
        if (last_row) state_d = LOAD_B;
      end
      LOAD_B: begin
        state_d  = RUN;
        loaded_d = 1'b1;
      end
      RUN: begin
        if (handshake) begin
          if (out_idx_q == LAST_OUT) begin
            out_idx_d = '0;
            state_d   = FIN;
          end else begin
            out_idx_d = out_idx_q + ADDRW'(1);
          end
        end
      end
      FIN: begin
        out_idx_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched configuration; reset aborts a run without done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      out_idx_q <= '0;
      loaded_q  <= 1'b0;
      m0_q      <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
      loaded_q  <= loaded_d;
      m0_q      <= m0_d;
      n_q       <= n_d;
    end
  end

  assign w_row  = bus.wmem_data_i;
  assign b_word = bus.bmem_data_i;

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == FIN);
  assign loaded_o = loaded_q;

  assign bus.dense_weights_data_o = w_row;
  assign bus.dense_biases_addr_o  = '0;
  assign bus.dense_biases_data_o  = b_word;
  assign bus.dense_dwscaling_m0_o = m0_q;
  assign bus.dense_dwscaling_n_o  = n_q;
  assign bus.feature_enable_o     = in_run;
  assign bus.flattendense_ready_o = bus.out_ready_i && in_run;
  assign bus.out_valid_o          = bus.flattendense_valid_i && in_run;
  assign bus.out_index_o          = out_idx_q;

endmodule

// File: tb/tb_dense_load_sequencer.sv
// Directed bench for dense_load_sequencer with a 1-cycle-latency ROM model.
// Latency: checks exact cycle placement of load strobes, valids and RUN entry.
// Backpressure: exercises out_ready_i toggling and stalls.
module tb_dense_load_sequencer;

  localparam int NN = 40;
  localparam int NR = 40;
  localparam logic [NN*32-1:0] BIAS_WORD = {NN{32'hB1A5_0F0F}};

  logic        clk;
  logic        rst;
  logic        start;
  logic        reload;
  logic [31:0] m0_cfg;
  logic [3:0]  n_cfg;
  logic        busy, done, loaded;

  int n_chk  = 0;
  int n_pass = 0;

  dense_load_sequencer_if bus ();

  dense_load_sequencer dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .reload_i (reload),
    .m0_cfg_i (m0_cfg),
    .n_cfg_i  (n_cfg),
    .busy_o   (busy),
    .done_o   (done),
    .loaded_o (loaded),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NN*8-1:0] rom_row(input logic [11:0] a);
    logic [7:0] b;
    b = a[7:0] * 8'd7 + 8'h13;
    return {NN{b}};
  endfunction

  // Parameter memories: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.wmem_req_o) bus.wmem_data_i <= rom_row(bus.wmem_addr_o);
    if (bus.bmem_req_o) bus.bmem_data_i <= BIAS_WORD;
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; reload = 1'b0; m0_cfg = '0; n_cfg = '0;
    bus.flattendense_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, loaded, bus.wmem_req_o, bus.bmem_req_o, bus.dense_weights_valid_o,
         bus.dense_biases_valid_o, bus.feature_enable_o} !== 8'b0) begin
      $display("FAIL reset_ctrl got=%b want=0", {busy, done, loaded, bus.wmem_req_o,
               bus.bmem_req_o, bus.dense_weights_valid_o, bus.dense_biases_valid_o,
               bus.feature_enable_o});
    end else n_pass++;
    n_chk++;
    if ({bus.out_index_o, bus.dense_dwscaling_m0_o, bus.dense_dwscaling_n_o} !== 48'b0) begin
      $display("FAIL reset_regs idx=%0d m0=%h n=%0d want all 0",
               bus.out_index_o, bus.dense_dwscaling_m0_o, bus.dense_dwscaling_n_o);
    end else n_pass++;
  endtask

  task automatic test_idle_valid();
    @(negedge clk);
    bus.flattendense_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_chk++;
      if ({bus.out_valid_o, bus.flattendense_ready_o, busy} !== 3'b000 || bus.out_index_o !== 12'd0) begin
        $display("FAIL idle_valid c=%0d ov=%b fr=%b busy=%b idx=%0d want 0/0/0/0",
                 c, bus.out_valid_o, bus.flattendense_ready_o, busy, bus.out_index_o);
      end else n_pass++;
    end
    bus.flattendense_valid_i = 1'b0; bus.out_ready_i = 1'b0;
  endtask

  // Start with reload_i=0 while not resident; expects a full load.
  task automatic test_full_load(input logic [31:0] m0, input logic [3:0] n);
    logic [7:0]  exp_f, got_f;
    logic [11:0] exp_a;
    @(negedge clk);
    start = 1'b1; reload = 1'b0; m0_cfg = m0; n_cfg = n;
    bus.flattendense_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      start  = (k == 5);
      reload = (k == 5);
      #1;
      // {wreq, wvalid, breq, bvalid, feature_en, loaded, done, busy}
      exp_f = {(k <= NR), (k >= 2 && k <= NR + 1), (k == NR + 1), (k == NR + 2),
               (k >= NR + 2), (k >= NR + 2), 1'b0, 1'b1};
      got_f = {bus.wmem_req_o, bus.dense_weights_valid_o, bus.bmem_req_o,
               bus.dense_biases_valid_o, bus.feature_enable_o, loaded, done, busy};
      n_chk++;
      if (got_f !== exp_f) $display("FAIL load_flags k=%0d got=%b want=%b", k, got_f, exp_f);
      else n_pass++;
      if (k <= NR) begin
        exp_a = 12'(k - 1);
        n_chk++;
        if (bus.wmem_addr_o !== exp_a)
          $display("FAIL wmem_addr k=%0d got=%0d want=%0d", k, bus.wmem_addr_o, exp_a);
        else n_pass++;
      end
      if (k >= 2 && k <= NR + 1) begin
        exp_a = 12'(k - 2);
        n_chk++;
        if (bus.dense_weights_addr_o !== exp_a || bus.dense_weights_data_o !== rom_row(exp_a))
          $display("FAIL weight_row k=%0d addr=%0d want=%0d data=%h want=%h", k,
                   bus.dense_weights_addr_o, exp_a, bus.dense_weights_data_o[15:0],
                   rom_row(exp_a) & 320'hFFFF);
        else n_pass++;
      end
      if (k == NR + 2) begin
        n_chk++;
        if (bus.dense_biases_data_o !== BIAS_WORD || bus.dense_biases_addr_o !== 12'd0)
          $display("FAIL bias_word addr=%0d data_lo=%h want 0/b1a50f0f",
                   bus.dense_biases_addr_o, bus.dense_biases_data_o[31:0]);
        else n_pass++;
        n_chk++;
        if (bus.dense_dwscaling_m0_o !== m0 || bus.dense_dwscaling_n_o !== n)
          $display("FAIL load_scaling m0=%h want=%h n=%0d want=%0d",
                   bus.dense_dwscaling_m0_o, m0, bus.dense_dwscaling_n_o, n);
        else n_pass++;
      end
    end
    start = 1'b0; reload = 1'b0;
  endtask

  // Drains a RUN phase; optionally toggles ready and pokes start mid-run.
  task automatic test_backpressure(input bit toggle, input bit poke_start);
    int  hs;
    bit  rdy;
    logic [11:0] exp_idx;
    hs = 0; exp_idx = '0;
    bus.flattendense_valid_i = 1'b1;
    for (int c = 0; c < 200 && hs < NN; c++) begin
      @(negedge clk);
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      bus.out_ready_i = rdy;
      start  = poke_start && (c == 11);
      reload = start;
      #1;
      n_chk++;
      if (bus.out_index_o !== exp_idx || bus.out_valid_o !== 1'b1 ||
          bus.flattendense_ready_o !== rdy || done !== 1'b0 || bus.feature_enable_o !== 1'b1)
        $display("FAIL run_step c=%0d idx=%0d want=%0d ov=%b fr=%b want=%b done=%b fe=%b",
                 c, bus.out_index_o, exp_idx, bus.out_valid_o, bus.flattendense_ready_o,
                 rdy, done, bus.feature_enable_o);
      else n_pass++;
      if (rdy) begin
        hs++;
        exp_idx++;
      end
    end
    @(negedge clk);
    start = 1'b0; reload = 1'b0;
    bus.out_ready_i = 1'b0; bus.flattendense_valid_i = 1'b0;
    #1;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.feature_enable_o !== 1'b0)
      $display("FAIL done_pulse done=%b busy=%b fe=%b want 1/1/0", done, busy, bus.feature_enable_o);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.out_index_o !== 12'd0)
      $display("FAIL after_done done=%b busy=%b idx=%0d want 0/0/0", done, busy, bus.out_index_o);
    else n_pass++;
  endtask

  task automatic test_no_reload();
    @(negedge clk);
    start = 1'b1; reload = 1'b0; m0_cfg = 32'h0000_A2C0; n_cfg = 4'd7;
    bus.out_ready_i = 1'b0; bus.flattendense_valid_i = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++;
    if (bus.feature_enable_o !== 1'b1 || loaded !== 1'b1 || busy !== 1'b1)
      $display("FAIL noreload_run fe=%b loaded=%b busy=%b want 1/1/1", bus.feature_enable_o, loaded, busy);
    else n_pass++;
    n_chk++;
    if (bus.dense_dwscaling_m0_o !== 32'h0000_A2C0 || bus.dense_dwscaling_n_o !== 4'd7)
      $display("FAIL noreload_scaling m0=%h want=0000a2c0 n=%0d want=7",
               bus.dense_dwscaling_m0_o, bus.dense_dwscaling_n_o);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (bus.wmem_req_o !== 1'b0 || bus.bmem_req_o !== 1'b0 || bus.dense_weights_valid_o !== 1'b0)
        $display("FAIL noreload_req c=%0d wreq=%b breq=%b wv=%b want 0",
                 c, bus.wmem_req_o, bus.bmem_req_o, bus.dense_weights_valid_o);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1; reload = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      start = 1'b0; reload = 1'b0;
      #1;
      if (bus.wmem_req_o && bus.wmem_addr_o == 12'd17) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL reach_row17 timeout got=0 want=1");
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if ({busy, done, loaded, bus.wmem_req_o, bus.bmem_req_o, bus.dense_weights_valid_o,
         bus.dense_biases_valid_o, bus.feature_enable_o} !== 8'b0 ||
        bus.dense_dwscaling_m0_o !== 32'd0 || bus.dense_dwscaling_n_o !== 4'd0)
      $display("FAIL midreset_out ctrl=%b m0=%h n=%0d want 0",
               {busy, done, loaded, bus.wmem_req_o, bus.bmem_req_o, bus.dense_weights_valid_o,
                bus.dense_biases_valid_o, bus.feature_enable_o},
               bus.dense_dwscaling_m0_o, bus.dense_dwscaling_n_o);
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0)
        $display("FAIL midreset_idle c=%0d done=%b busy=%b loaded=%b want 0", c, done, busy, loaded);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_full_load(32'h1234_5678, 4'd3);
    test_backpressure(1'b1, 1'b1);
    test_no_reload();
    test_backpressure(1'b0, 1'b0);
    test_mid_reset();
    test_full_load(32'h0BAD_CAFE, 4'd9);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
